// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA timing chain (hsync, vsync_timing and the
//   vga_timing wrapper).
//   - phase_t       : vertical/horizontal phase encoding (ACTIVE/FRONT/SYNC/BACK)
//   - *_DEF         : 640x480@60 default timing constants
//   - count_width() : counter width for a period of n counts (min 1 bit)
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  // Horizontal defaults (pixel clocks)
  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

  // Vertical defaults (lines)
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Width of a counter spanning 0..n-1; a single-count period still needs 1 bit.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : vga_timing_pkg

// File: rtl/vsync_timing.sv
// ---------------------------------------------------------------------------
// vsync_timing
//   Vertical timing stage fed by the horizontal generator's pixel count.
//   Advances one line each time h_count reaches H_TOTAL-1, so the new line
//   number appears together with h_count wrapping to 0.
//
//   Ports:
//     clk_in      in   pixel clock
//     resetn      in   synchronous, active-low reset
//     h_count     in   horizontal pixel count from hsync
//     v_count     out  current line, 0..V_TOTAL-1
//     v_blank     out  high outside the visible lines
//     vsync       out  vertical sync, polarity set by SYNC_ACTIVE_LOW
//     frame_start out  one-clock pulse on the first pixel clock of line 0
// ---------------------------------------------------------------------------
module vsync_timing
  import vga_timing_pkg::*;
#(
  parameter int   H_TOTAL         = H_TOTAL_DEF,
  parameter int   FRAME_HEIGHT    = V_VISIBLE_DEF,
  parameter int   FRONT_PORCH     = V_FRONT_DEF,
  parameter int   VSYNC_WIDTH     = V_SYNC_DEF,
  parameter int   BACK_PORCH      = V_BACK_DEF,
  parameter logic SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                                       clk_in,
  input  logic                                       resetn,
  input  logic [count_width(H_TOTAL)-1:0]            h_count,
  output logic [count_width(FRAME_HEIGHT + FRONT_PORCH
                            + VSYNC_WIDTH + BACK_PORCH)-1:0] v_count,
  output logic                                       v_blank,
  output logic                                       vsync,
  output logic                                       frame_start
);

  localparam int V_TOTAL   = FRAME_HEIGHT + FRONT_PORCH + VSYNC_WIDTH + BACK_PORCH;
  localparam int H_COUNT_W = count_width(H_TOTAL);
  localparam int V_COUNT_W = count_width(V_TOTAL);

  // Last line of each phase; the phase changes when that line is left.
  localparam logic [H_COUNT_W-1:0] H_LAST      = H_COUNT_W'(H_TOTAL - 1);
  localparam logic [V_COUNT_W-1:0] ACTIVE_LAST = V_COUNT_W'(FRAME_HEIGHT - 1);
  localparam logic [V_COUNT_W-1:0] FRONT_LAST  = V_COUNT_W'(FRAME_HEIGHT + FRONT_PORCH - 1);
  localparam logic [V_COUNT_W-1:0] SYNC_LAST   = V_COUNT_W'(FRAME_HEIGHT + FRONT_PORCH
                                                            + VSYNC_WIDTH - 1);
  localparam logic [V_COUNT_W-1:0] V_LAST      = V_COUNT_W'(V_TOTAL - 1);

  generate
    if ((FRAME_HEIGHT < 1) || (FRONT_PORCH < 1) || (VSYNC_WIDTH < 1)
        || (BACK_PORCH < 1) || (H_TOTAL < 2)) begin : g_bad_params
      $error("vsync_timing: vertical widths must be >= 1 and H_TOTAL >= 2");
    end
  endgenerate

  logic [V_COUNT_W-1:0] v_count_reg;
  phase_t               phase_reg;
  logic                 frame_start_reg;

  logic line_end;
  logic v_last;

  // Exact match only: out-of-range h_count values never look like a line end.
  assign line_end = (h_count == H_LAST);
  assign v_last   = (v_count_reg == V_LAST);

  // Line counter, phase FSM and frame strobe share the same update edge so
  // the phase is always the one implied by v_count.
  always_ff @(posedge clk_in) begin
    if (!resetn) begin
      v_count_reg     <= '0;
      phase_reg       <= ACTIVE;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= line_end && v_last;
      if (line_end) begin
        v_count_reg <= v_last ? '0 : v_count_reg + V_COUNT_W'(1);
        case (phase_reg)
          ACTIVE:  if (v_count_reg == ACTIVE_LAST) phase_reg <= FRONT;
          FRONT:   if (v_count_reg == FRONT_LAST)  phase_reg <= SYNC;
          SYNC:    if (v_count_reg == SYNC_LAST)   phase_reg <= BACK;
          BACK:    if (v_last)                     phase_reg <= ACTIVE;
          default:                                 phase_reg <= ACTIVE;
        endcase
      end
    end
  end

  // Decodes of the phase register: same cycle as the matching v_count.
  logic vsync_raw;
  assign vsync_raw   = (phase_reg == SYNC);
  assign v_count     = v_count_reg;
  assign v_blank     = (phase_reg != ACTIVE);
  assign vsync       = SYNC_ACTIVE_LOW ? ~vsync_raw : vsync_raw;
  assign frame_start = frame_start_reg;

endmodule : vsync_timing

// File: tb/tb_vsync_timing.sv
// ---------------------------------------------------------------------------
// tb_vsync_timing
//   Two instances: 640x480@60 defaults (active-low sync) and a tiny
//   configuration (H_TOTAL=4, V_TOTAL=5, active-high sync). A line-level
//   reference model tracks the current line number for each and derives the
//   expected outputs from the line ranges.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vsync_timing;

  // Default configuration
  localparam int D_HT = 800;
  localparam int D_FH = 480;
  localparam int D_FP = 10;
  localparam int D_SW = 2;
  localparam int D_BP = 33;
  localparam int D_VT = D_FH + D_FP + D_SW + D_BP;

  // Small configuration
  localparam int S_HT = 4;
  localparam int S_FH = 2;
  localparam int S_FP = 1;
  localparam int S_SW = 1;
  localparam int S_BP = 1;
  localparam int S_VT = S_FH + S_FP + S_SW + S_BP;

  logic       clk_in = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] d_h_count = '0;
  logic [1:0] s_h_count = '0;

  logic [9:0] d_v_count;
  logic       d_v_blank, d_vsync, d_frame_start;
  logic [2:0] s_v_count;
  logic       s_v_blank, s_vsync, s_frame_start;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int   m_line_d = 0;
  logic m_fs_d   = 1'b0;
  int   m_line_s = 0;
  logic m_fs_s   = 1'b0;

  always #5 clk_in = ~clk_in;

  vsync_timing dut_d (
    .clk_in      (clk_in),
    .resetn      (resetn),
    .h_count     (d_h_count),
    .v_count     (d_v_count),
    .v_blank     (d_v_blank),
    .vsync       (d_vsync),
    .frame_start (d_frame_start)
  );

  vsync_timing #(
    .H_TOTAL         (S_HT),
    .FRAME_HEIGHT    (S_FH),
    .FRONT_PORCH     (S_FP),
    .VSYNC_WIDTH     (S_SW),
    .BACK_PORCH      (S_BP),
    .SYNC_ACTIVE_LOW (1'b0)
  ) dut_s (
    .clk_in      (clk_in),
    .resetn      (resetn),
    .h_count     (s_h_count),
    .v_count     (s_v_count),
    .v_blank     (s_v_blank),
    .vsync       (s_vsync),
    .frame_start (s_frame_start)
  );

  // Expected {v_count, v_blank, vsync, frame_start} from the line number.
  function automatic logic [12:0] exp_d();
    logic sync_on;
    sync_on = (m_line_d >= D_FH + D_FP) && (m_line_d < D_FH + D_FP + D_SW);
    return {10'(m_line_d), (m_line_d >= D_FH), ~sync_on, m_fs_d};
  endfunction

  function automatic logic [5:0] exp_s();
    logic sync_on;
    sync_on = (m_line_s >= S_FH + S_FP) && (m_line_s < S_FH + S_FP + S_SW);
    return {3'(m_line_s), (m_line_s >= S_FH), sync_on, m_fs_s};
  endfunction

  // Apply inputs for one clock, advance the model at the edge, sample 1ns later.
  task automatic tick(input logic rn, input int hd, input int hs);
    resetn    = rn;
    d_h_count = 10'(hd);
    s_h_count = 2'(hs);
    @(posedge clk_in);
    if (!rn) begin
      m_line_d = 0; m_fs_d = 1'b0;
      m_line_s = 0; m_fs_s = 1'b0;
    end else begin
      m_fs_d = (hd == D_HT - 1) && (m_line_d == D_VT - 1);
      if (hd == D_HT - 1) m_line_d = (m_line_d + 1) % D_VT;
      m_fs_s = (hs == S_HT - 1) && (m_line_s == S_VT - 1);
      if (hs == S_HT - 1) m_line_s = (m_line_s + 1) % S_VT;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, D_HT - 1, S_HT - 1);
      tests_run++;
      if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== 13'b0_0000_0000_0010) begin
        tests_failed++;
        $display("FAIL reset_d: got %h expected %h", {d_v_count, d_v_blank, d_vsync, d_frame_start}, 13'h2);
      end
      tests_run++;
      if ({s_v_count, s_v_blank, s_vsync, s_frame_start} !== 6'b000_000) begin
        tests_failed++;
        $display("FAIL reset_s: got %h expected %h", {s_v_count, s_v_blank, s_vsync, s_frame_start}, 6'h0);
      end
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_ideal_ramp();
    int first_fs = -1;
    int fs_cnt   = 0;
    int sync_cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      tick(1'b1, i % D_HT, i % S_HT);
      tests_run++;
      if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== exp_d()) begin
        tests_failed++;
        $display("FAIL ramp_d cyc %0d: got %h expected %h", i, {d_v_count, d_v_blank, d_vsync, d_frame_start}, exp_d());
      end
      tests_run++;
      if ({s_v_count, s_v_blank, s_vsync, s_frame_start} !== exp_s()) begin
        tests_failed++;
        $display("FAIL ramp_s cyc %0d: got %h expected %h", i, {s_v_count, s_v_blank, s_vsync, s_frame_start}, exp_s());
      end
      if (s_frame_start) begin
        fs_cnt++;
        if (first_fs < 0) first_fs = i;
      end
      if (s_vsync) sync_cnt++;
    end
    // Wrap happens on the 20th edge (index 19); pulse every 20 cycles.
    tests_run++;
    if (first_fs != 19) begin
      tests_failed++;
      $display("FAIL ramp_first_fs: got %0d expected 19", first_fs);
    end
    tests_run++;
    if (fs_cnt != 100) begin
      tests_failed++;
      $display("FAIL ramp_fs_count: got %0d expected 100", fs_cnt);
    end
    tests_run++;
    if (sync_cnt != 400) begin
      tests_failed++;
      $display("FAIL ramp_vsync_cycles: got %0d expected 400", sync_cnt);
    end
    $display("[TB] test_ideal_ramp done: small fs=%0d first=%0d", fs_cnt, first_fs);
  endtask

  // One line per clock on the default instance to cover whole frames quickly.
  task automatic test_fast_frames();
    int low_cnt = 0;
    int fs_cnt  = 0;
    tick(1'b0, 0, 0);
    for (int j = 0; j < 1100; j++) begin
      tick(1'b1, D_HT - 1, $urandom_range(0, S_HT - 1));
      tests_run++;
      if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== exp_d()) begin
        tests_failed++;
        $display("FAIL fast_d cyc %0d: got %h expected %h", j, {d_v_count, d_v_blank, d_vsync, d_frame_start}, exp_d());
      end
      tests_run++;
      if ({s_v_count, s_v_blank, s_vsync, s_frame_start} !== exp_s()) begin
        tests_failed++;
        $display("FAIL fast_s cyc %0d: got %h expected %h", j, {s_v_count, s_v_blank, s_vsync, s_frame_start}, exp_s());
      end
      if (!d_vsync) low_cnt++;
      if (d_frame_start) fs_cnt++;
    end
    tests_run++;
    if (low_cnt != 4) begin
      tests_failed++;
      $display("FAIL fast_vsync_low: got %0d expected 4", low_cnt);
    end
    tests_run++;
    if (fs_cnt != 2) begin
      tests_failed++;
      $display("FAIL fast_fs_count: got %0d expected 2", fs_cnt);
    end
    $display("[TB] test_fast_frames done: vsync_low=%0d fs=%0d", low_cnt, fs_cnt);
  endtask

  task automatic test_hold();
    int fs_seen = 0;
    tick(1'b0, 0, 0);
    for (int j = 0; j < D_FH + D_FP; j++) tick(1'b1, D_HT - 1, S_HT - 1);
    // Now on line 490 (sync active) and small on line 490 % 5 = 0.
    for (int j = 0; j < 2200; j++) begin
      tick(1'b1, (j < 2000) ? 5 : D_HT, 1);
      tests_run++;
      if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== {10'd490, 1'b1, 1'b0, 1'b0}) begin
        tests_failed++;
        $display("FAIL hold_d cyc %0d: got %h expected %h", j, {d_v_count, d_v_blank, d_vsync, d_frame_start}, {10'd490, 3'b100});
      end
      tests_run++;
      if ({s_v_count, s_v_blank, s_vsync, s_frame_start} !== exp_s()) begin
        tests_failed++;
        $display("FAIL hold_s cyc %0d: got %h expected %h", j, {s_v_count, s_v_blank, s_vsync, s_frame_start}, exp_s());
      end
      if (d_frame_start || s_frame_start) fs_seen++;
    end
    tests_run++;
    if (fs_seen != 0) begin
      tests_failed++;
      $display("FAIL hold_no_fs: got %0d expected 0", fs_seen);
    end
    $display("[TB] test_hold done");
  endtask

  task automatic test_mid_reset();
    tick(1'b0, 0, 0);
    for (int j = 0; j < 300; j++) tick(1'b1, D_HT - 1, 0);
    tests_run++;
    if (d_v_count !== 10'd300) begin
      tests_failed++;
      $display("FAIL midrst_pre: got %0d expected 300", d_v_count);
    end
    tick(1'b0, D_HT - 1, S_HT - 1);
    tests_run++;
    if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== {10'd0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL midrst_d: got %h expected %h", {d_v_count, d_v_blank, d_vsync, d_frame_start}, 13'h2);
    end
    for (int i = 0; i < 1600; i++) begin
      tick(1'b1, i % D_HT, i % S_HT);
      tests_run++;
      if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== exp_d()) begin
        tests_failed++;
        $display("FAIL midrst_resume_d cyc %0d: got %h expected %h", i, {d_v_count, d_v_blank, d_vsync, d_frame_start}, exp_d());
      end
    end
    tests_run++;
    if (d_v_count !== 10'd2) begin
      tests_failed++;
      $display("FAIL midrst_resume_line: got %0d expected 2", d_v_count);
    end
    $display("[TB] test_mid_reset done");
  endtask

  task automatic test_random();
    logic prev_d = 1'b0;
    logic prev_s = 1'b0;
    for (int j = 0; j < 5000; j++) begin
      int   hd;
      logic rn;
      hd = ($urandom_range(0, 1) == 0) ? D_HT - 1 : int'($urandom_range(0, 1023));
      rn = ($urandom_range(0, 499) != 0);
      tick(rn, hd, $urandom_range(0, S_HT - 1));
      tests_run++;
      if ({d_v_count, d_v_blank, d_vsync, d_frame_start} !== exp_d()) begin
        tests_failed++;
        $display("FAIL rand_d cyc %0d: got %h expected %h", j, {d_v_count, d_v_blank, d_vsync, d_frame_start}, exp_d());
      end
      tests_run++;
      if ({s_v_count, s_v_blank, s_vsync, s_frame_start} !== exp_s()) begin
        tests_failed++;
        $display("FAIL rand_s cyc %0d: got %h expected %h", j, {s_v_count, s_v_blank, s_vsync, s_frame_start}, exp_s());
      end
      tests_run++;
      if ((prev_d && d_frame_start) || (prev_s && s_frame_start)) begin
        tests_failed++;
        $display("FAIL rand_fs_width cyc %0d: got two-cycle pulse expected one", j);
      end
      prev_d = d_frame_start;
      prev_s = s_frame_start;
    end
    $display("[TB] test_random done");
  endtask

  initial begin
    test_reset();
    test_ideal_ramp();
    test_fast_frames();
    test_hold();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_vsync_timing
